// File: rtl/hdmi_pkg.sv
// Shared encodings for the HDMI data-island packetizer: mode codes, preamble CTL, BCH polynomial, FSM states.
// Latency: n/a (types, constants and a combinational BCH step helper only).
// Backpressure: n/a.
package hdmi_pkg;

    localparam logic [1:0] MODE_CTRL     = 2'd0;
    localparam logic [1:0] MODE_PREAMBLE = 2'd1;
    localparam logic [1:0] MODE_GUARD    = 2'd2;
    localparam logic [1:0] MODE_DATA     = 2'd3;

    // CTL3..CTL0 announcing a data island (CTL0 = 1, CTL1 = 0, CTL2 = 1, CTL3 = 0)
    localparam logic [3:0] CTL_DATA_PREAMBLE = 4'b0101;

    localparam logic [7:0] BCH_POLY = 8'h83;
    localparam int         BODY_LEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LGUARD,
        ST_BODY,
        ST_TGUARD
    } state_e;

    // One LSB-first step of the BCH parity shift register
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic bit_in);
        logic fb;
        fb = bit_in ^ ecc[0];
        return (ecc >> 1) ^ (fb ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_bch_ecc8.sv
// Serial BCH parity accumulator (8-bit, poly 0x83), BITS_PER_CYCLE bits folded per clock, bit 0 first.
// Latency: ecc_o reflects all data presented up to and including the previous enabled cycle.
// Backpressure: none; clr_i has priority over en_i.
module hdmi_bch_ecc8
    import hdmi_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic [BITS_PER_CYCLE-1:0] dat_i,
    output logic [7:0]                ecc_o
);

    logic [7:0] ecc_q;
    logic [7:0] ecc_d;

    // Fold this cycle's data bits into the parity, lowest bit first
    always_comb begin
        ecc_d = ecc_q;
        if (clr_i) begin
            ecc_d = '0;
        end else if (en_i) begin
            for (int b = 0; b < BITS_PER_CYCLE; b++) begin
                ecc_d = bch_step(ecc_d, dat_i[b]);
            end
        end
    end

    // Parity register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ecc_q <= '0;
        end else begin
            ecc_q <= ecc_d;
        end
    end

    assign ecc_o = ecc_q;

endmodule

// File: rtl/hdmi_island_packetizer.sv
// Serialises one data-island packet (header + 4 subpackets) into preamble/guard/body nibbles for ch0..ch2.
// Latency: all outputs registered; first preamble cycle appears one clock after accept, island lasts PREAMBLE_LEN+2*GUARD_LEN+32 cycles.
// Backpressure: pkt_ready high only in IDLE, no queuing; macro HDMI_PKT_ECC_EN builds BCH parity, otherwise parity bits pass verbatim.
module hdmi_island_packetizer
    import hdmi_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [31:0] pkt_header,
    input  logic [63:0] pkt_sub0,
    input  logic [63:0] pkt_sub1,
    input  logic [63:0] pkt_sub2,
    input  logic [63:0] pkt_sub3,
    input  logic        hsync,
    input  logic        vsync,
    output logic [1:0]  mode,
    output logic [3:0]  ctl,
    output logic [3:0]  ch0_data,
    output logic [3:0]  ch1_data,
    output logic [3:0]  ch2_data,
    output logic        busy
);

    localparam int CNT_W = 5;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hdr_sr_q, hdr_sr_d;
    logic [3:0][63:0] sub_sr_q, sub_sr_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [3:0]       ch0_q, ch0_d;
    logic [3:0]       ch1_q, ch1_d;
    logic [3:0]       ch2_q, ch2_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             hdr_bit;
    logic [3:0]       lane1_bits;
    logic [3:0]       lane2_bits;

    assign accept = (state_q == ST_IDLE) && pkt_valid;

    // Island sequencing: preamble, leading guard, body, trailing guard
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = '0;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_LGUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_LGUARD: begin
                if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                    state_d = ST_BODY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_BODY: begin
                if (cnt_q == CNT_W'(BODY_LEN - 1)) begin
                    state_d = ST_TGUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_TGUARD: begin
                if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Load shift registers on accept; advance one header bit / two subpacket bits per body cycle
    always_comb begin
        hdr_sr_d = hdr_sr_q;
        sub_sr_d = sub_sr_q;
        if (accept) begin
            hdr_sr_d    = pkt_header;
            sub_sr_d[0] = pkt_sub0;
            sub_sr_d[1] = pkt_sub1;
            sub_sr_d[2] = pkt_sub2;
            sub_sr_d[3] = pkt_sub3;
        end else if (state_d == ST_BODY) begin
            hdr_sr_d = {1'b0, hdr_sr_q[31:1]};
            for (int k = 0; k < 4; k++) begin
                sub_sr_d[k] = {2'b00, sub_sr_q[k][63:2]};
            end
        end
    end

`ifdef HDMI_PKT_ECC_EN
    logic            hdr_ecc_en;
    logic            sub_ecc_en;
    logic [7:0]      hdr_ecc;
    logic [3:0][7:0] sub_ecc;

    // Parity accumulates while payload bits are on the wire; it is complete by the first parity slot
    assign hdr_ecc_en = (state_d == ST_BODY) && (cnt_d < 5'd24);
    assign sub_ecc_en = (state_d == ST_BODY) && (cnt_d < 5'd28);

    hdmi_bch_ecc8 #(.BITS_PER_CYCLE(1)) u_hdr_ecc (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .clr_i   (accept),
        .en_i    (hdr_ecc_en),
        .dat_i   (hdr_sr_q[0]),
        .ecc_o   (hdr_ecc)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
        hdmi_bch_ecc8 #(.BITS_PER_CYCLE(2)) u_sub_ecc (
            .clk_i   (clk),
            .rst_n_i (reset_n),
            .clr_i   (accept),
            .en_i    (sub_ecc_en),
            .dat_i   (sub_sr_q[k][1:0]),
            .ecc_o   (sub_ecc[k])
        );
    end
`endif

    // Body bit selection: payload from the shift registers, parity slots from the ECC registers when built
    always_comb begin
        hdr_bit = hdr_sr_q[0];
        for (int k = 0; k < 4; k++) begin
            lane1_bits[k] = sub_sr_q[k][0];
            lane2_bits[k] = sub_sr_q[k][1];
        end
`ifdef HDMI_PKT_ECC_EN
        if (cnt_d >= 5'd24) begin
            hdr_bit = hdr_ecc[cnt_d[2:0]];
        end
        if (cnt_d >= 5'd28) begin
            for (int k = 0; k < 4; k++) begin
                lane1_bits[k] = sub_ecc[k][{cnt_d[1:0], 1'b0}];
                lane2_bits[k] = sub_ecc[k][{cnt_d[1:0], 1'b1}];
            end
        end
`endif
    end

    // Output decode from the next state so every output is a plain register
    always_comb begin
        mode_d = MODE_CTRL;
        ctl_d  = 4'b0000;
        ch0_d  = {2'b00, vsync, hsync};
        ch1_d  = 4'b0000;
        ch2_d  = 4'b0000;
        rdy_d  = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_PREAMBLE: begin
                mode_d = MODE_PREAMBLE;
                ctl_d  = CTL_DATA_PREAMBLE;
            end
            ST_LGUARD, ST_TGUARD: begin
                mode_d = MODE_GUARD;
                ch0_d  = {2'b11, vsync, hsync};
            end
            ST_BODY: begin
                mode_d = MODE_DATA;
                ch0_d  = {(cnt_d != '0), hdr_bit, vsync, hsync};
                ch1_d  = lane1_bits;
                ch2_d  = lane2_bits;
            end
            default: begin
                mode_d = MODE_CTRL;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hdr_sr_q <= '0;
            sub_sr_q <= '0;
            mode_q   <= MODE_CTRL;
            ctl_q    <= '0;
            ch0_q    <= '0;
            ch1_q    <= '0;
            ch2_q    <= '0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hdr_sr_q <= hdr_sr_d;
            sub_sr_q <= sub_sr_d;
            mode_q   <= mode_d;
            ctl_q    <= ctl_d;
            ch0_q    <= ch0_d;
            ch1_q    <= ch1_d;
            ch2_q    <= ch2_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign pkt_ready = rdy_q;
    assign busy      = busy_q;
    assign mode      = mode_q;
    assign ctl       = ctl_q;
    assign ch0_data  = ch0_q;
    assign ch1_data  = ch1_q;
    assign ch2_data  = ch2_q;

endmodule

// File: tb/tb_hdmi_island_packetizer.sv
// Self-checking bench for hdmi_island_packetizer: per-cycle scoreboard of expected output words.
// Latency: expected island words are queued at accept and compared one per clock, #1 after the rising edge.
// Backpressure: packets wait in a pending queue with pkt_valid held until the bench model expects acceptance.
module tb_hdmi_island_packetizer;

    localparam int PRE = 8;
    localparam int GRD = 2;
    localparam int ISL = PRE + 2 * GRD + 32;
    localparam int B0  = PRE + GRD + 1;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] ctl;
        logic [3:0] ch0;
        logic [3:0] ch1;
        logic [3:0] ch2;
        logic       rdy;
        logic       busy;
    } obs_t;

    typedef struct packed {
        logic [31:0] hdr;
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] s3;
    } pkt_t;

    logic        clk;
    logic        reset_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_header;
    logic [63:0] pkt_sub0, pkt_sub1, pkt_sub2, pkt_sub3;
    logic        hsync, vsync;
    logic [1:0]  mode;
    logic [3:0]  ctl, ch0_data, ch1_data, ch2_data;
    logic        busy;

    obs_t        sb_q[$];
    pkt_t        pend_q[$];
    logic [31:0] acc_q[$];
    obs_t        exp_w, obs_w;
    logic        exp_rdy;
    logic        hv_rand;
    int          n_checks, n_fail, cyc, n_acc;

    hdmi_island_packetizer #(.PREAMBLE_LEN(PRE), .GUARD_LEN(GRD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_header (pkt_header),
        .pkt_sub0   (pkt_sub0),
        .pkt_sub1   (pkt_sub1),
        .pkt_sub2   (pkt_sub2),
        .pkt_sub3   (pkt_sub3),
        .hsync      (hsync),
        .vsync      (vsync),
        .mode       (mode),
        .ctl        (ctl),
        .ch0_data   (ch0_data),
        .ch1_data   (ch1_data),
        .ch2_data   (ch2_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bch(input logic [63:0] d, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int b = 0; b < n; b++) begin
            fb = d[b] ^ e[0];
            e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    // Expected output word j cycles after accept (j = 1..ISL); ch0[1:0] filled in at compare time
    function automatic obs_t island_word(input pkt_t p, input int j);
        obs_t        w;
        logic [63:0] s [4];
        logic        hb, b1, b2;
        logic [7:0]  e;
        int          i;
        s[0] = p.s0; s[1] = p.s1; s[2] = p.s2; s[3] = p.s3;
        w = '0;
        w.busy = 1'b1;
        if (j <= PRE) begin
            w.mode = 2'd1;
            w.ctl  = 4'b0101;
        end else if (j <= PRE + GRD || j > PRE + GRD + 32) begin
            w.mode = 2'd2;
            w.ch0  = 4'b1100;
        end else begin
            i  = j - B0;
            w.mode = 2'd3;
            hb = p.hdr[i];
`ifdef HDMI_PKT_ECC_EN
            if (i >= 24) begin
                e  = bch({32'h0, p.hdr}, 24);
                hb = e[i - 24];
            end
`endif
            w.ch0 = {(i != 0), hb, 2'b00};
            for (int k = 0; k < 4; k++) begin
                b1 = s[k][2 * i];
                b2 = s[k][2 * i + 1];
`ifdef HDMI_PKT_ECC_EN
                if (i >= 28) begin
                    e  = bch(s[k], 56);
                    b1 = e[2 * (i - 28)];
                    b2 = e[2 * (i - 28) + 1];
                end
`endif
                w.ch1[k] = b1;
                w.ch2[k] = b2;
            end
        end
        return w;
    endfunction

    task automatic drive_pending();
        if (pend_q.size() > 0) begin
            pkt_valid  = 1'b1;
            pkt_header = pend_q[0].hdr;
            pkt_sub0   = pend_q[0].s0;
            pkt_sub1   = pend_q[0].s1;
            pkt_sub2   = pend_q[0].s2;
            pkt_sub3   = pend_q[0].s3;
        end else begin
            pkt_valid = 1'b0;
        end
    endtask

    // Advance one clock: update the scoreboard, sample the DUT into obs_w, then drive the next inputs
    task automatic tick();
        logic       acc;
        logic [1:0] hv_prev;
        pkt_t       cur;
        acc     = pkt_valid && exp_rdy && reset_n;
        hv_prev = {vsync, hsync};
        cur     = {pkt_header, pkt_sub0, pkt_sub1, pkt_sub2, pkt_sub3};
        @(posedge clk);
        #1;
        if (!reset_n) begin
            sb_q.delete();
            exp_w = '0;
            exp_w.rdy = 1'b1;
            cyc = 0;
        end else begin
            if (acc) begin
                for (int j = 1; j <= ISL; j++) sb_q.push_back(island_word(cur, j));
                acc_q.push_back(cur.hdr);
                n_acc++;
                cyc = 0;
            end
            cyc++;
            if (sb_q.size() > 0) begin
                exp_w = sb_q.pop_front();
            end else begin
                exp_w = '0;
                exp_w.rdy = 1'b1;
            end
            exp_w.ch0[1:0] = hv_prev;
        end
        exp_rdy = exp_w.rdy;
        obs_w = {mode, ctl, ch0_data, ch1_data, ch2_data, pkt_ready, busy};
        if (acc) pend_q.delete(0);
        drive_pending();
        if (hv_rand) {vsync, hsync} = 2'($urandom_range(0, 3));
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.hdr = $urandom;
        p.s0  = {$urandom, $urandom};
        p.s1  = {$urandom, $urandom};
        p.s2  = {$urandom, $urandom};
        p.s3  = {$urandom, $urandom};
        return p;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; pkt_valid = 1'b0; hv_rand = 1'b0; exp_rdy = 1'b1;
        pkt_header = '0; pkt_sub0 = '0; pkt_sub1 = '0; pkt_sub2 = '0; pkt_sub3 = '0;
        hsync = 1'b1; vsync = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL reset_state c=%0d got=%h want=%h", c, obs_w, exp_w);
            end
        end
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL reset_release c=%0d got=%h want=%h", c, obs_w, exp_w);
            end
        end
    endtask

    task automatic test_null_packet();
        hsync = 1'b1; vsync = 1'b0; hv_rand = 1'b0;
        pend_q.push_back('0);
        drive_pending();
        for (int c = 0; c < ISL + 2; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL null_pkt cyc=%0d got=%h want=%h", cyc, obs_w, exp_w);
            end
            if (cyc == ISL + 1) begin
                n_checks++;
                if (pkt_ready !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL null_ready_45 rdy=%b busy=%b want rdy=1 busy=0", pkt_ready, busy);
                end
            end
        end
    endtask

    task automatic test_header_parity();
        pkt_t       p;
        logic [7:0] par, want;
        p = '0;
        p.hdr = 32'hA5_000001;
        hv_rand = 1'b1;
        par = '0;
        pend_q.push_back(p);
        drive_pending();
`ifdef HDMI_PKT_ECC_EN
        want = 8'h4A;
`else
        want = 8'hA5;
`endif
        for (int c = 0; c < ISL + 2; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL hdr_pkt cyc=%0d got=%h want=%h", cyc, obs_w, exp_w);
            end
            if (cyc >= B0 + 24 && cyc <= B0 + 31) par[cyc - B0 - 24] = ch0_data[2];
        end
        n_checks++;
        if (par !== want) begin
            n_fail++;
            $display("FAIL hdr_parity got=%h want=%h", par, want);
        end
    endtask

    task automatic test_sub_parity();
        pkt_t       p;
        logic [7:0] par, want;
        logic [3:0] first_ch1;
        p = '0;
        p.s0 = {8'hC3, 56'h1};
        hv_rand = 1'b1;
        par = '0;
        first_ch1 = 'x;
        pend_q.push_back(p);
        drive_pending();
`ifdef HDMI_PKT_ECC_EN
        want = bch(64'h1, 56);
`else
        want = 8'hC3;
`endif
        for (int c = 0; c < ISL + 2; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL sub_pkt cyc=%0d got=%h want=%h", cyc, obs_w, exp_w);
            end
            if (cyc == B0) first_ch1 = ch1_data;
            if (cyc >= B0 + 28 && cyc <= B0 + 31) begin
                par[2 * (cyc - B0 - 28)]     = ch1_data[0];
                par[2 * (cyc - B0 - 28) + 1] = ch2_data[0];
            end
        end
        n_checks++;
        if (first_ch1 !== 4'b0001) begin
            n_fail++;
            $display("FAIL sub_first_ch1 got=%b want=0001", first_ch1);
        end
        n_checks++;
        if (par !== want) begin
            n_fail++;
            $display("FAIL sub_parity got=%h want=%h", par, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hdrs[$];
        int          acc0;
        pkt_t        p;
        hv_rand = 1'b1;
        acc0 = n_acc;
        acc_q.delete();
        for (int n = 0; n < 3; n++) begin
            p = rand_pkt();
            hdrs.push_back(p.hdr);
            pend_q.push_back(p);
        end
        drive_pending();
        for (int c = 0; c < 3 * (ISL + 1) + 2; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL b2b c=%0d got=%h want=%h", c, obs_w, exp_w);
            end
        end
        n_checks++;
        if (n_acc - acc0 != 3) begin
            n_fail++;
            $display("FAIL b2b_accepts got=%0d want=3", n_acc - acc0);
        end
        for (int n = 0; n < 3; n++) begin
            n_checks++;
            if (acc_q.size() <= n || acc_q[n] !== hdrs[n]) begin
                n_fail++;
                $display("FAIL b2b_order n=%0d want=%h", n, hdrs[n]);
            end
        end
    endtask

    task automatic test_reset_mid_island();
        hv_rand = 1'b1;
        pend_q.push_back(rand_pkt());
        drive_pending();
        for (int c = 0; c < ISL && !(cyc == B0 + 10 && n_acc > 0 && busy === 1'b1); c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL mid_pre c=%0d got=%h want=%h", c, obs_w, exp_w);
            end
        end
        n_checks++;
        if (cyc != B0 + 10) begin
            n_fail++;
            $display("FAIL mid_reach_body10 got cyc=%0d want=%0d", cyc, B0 + 10);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({mode, ctl, ch0_data, ch1_data, ch2_data, pkt_ready, busy} !== 20'h00002) begin
            n_fail++;
            $display("FAIL mid_async got=%h want=00002",
                     {mode, ctl, ch0_data, ch1_data, ch2_data, pkt_ready, busy});
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL mid_in_reset c=%0d got=%h want=%h", c, obs_w, exp_w);
            end
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (obs_w !== exp_w || pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release got=%h want=%h", obs_w, exp_w);
        end
        pend_q.push_back(rand_pkt());
        drive_pending();
        for (int c = 0; c < ISL + 2; c++) begin
            tick();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL mid_next_pkt cyc=%0d got=%h want=%h", cyc, obs_w, exp_w);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; n_acc = 0;
        test_reset();
        test_null_packet();
        test_header_parity();
        test_sub_parity();
        test_back_to_back();
        test_reset_mid_island();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
